// File: rtl/demo_ctrl_pkg.sv
// Shared types and constants for the demo start-button conditioning block.
package demo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        FIRE    = 2'd2,
        RELEASE = 2'd3
    } ctrl_state_e;

    localparam logic MODE_WRITE   = 1'b1;
    localparam logic MODE_READ    = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/demo_start_ctrl_sync_debounce.sv
// Synchroniser plus counting debouncer for an active-low button.
// Emits the debounced level and a one-cycle strobe when it goes pressed.
module sync_debounce
    import demo_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din_n,
    output logic stable_n,
    output logic press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] prime_cnt_q, prime_cnt_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic          primed_q, primed_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_n};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A press only counts once the button has been seen released for a full
    // debounce window since reset, so a button held through reset cannot fire.
    always_comb begin
        cnt_d       = cnt_q;
        prime_cnt_d = prime_cnt_q;
        stable_d    = stable_q;
        press_d     = 1'b0;
        primed_d    = primed_q;

        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                cnt_d    = '0;
                press_d  = (synced != BTN_RELEASED) && primed_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end

        if (!primed_q) begin
            if (synced == BTN_RELEASED) begin
                if (prime_cnt_q == CNT_LAST) begin
                    primed_d = 1'b1;
                end else begin
                    prime_cnt_d = prime_cnt_q + CNT_ONE;
                end
            end else begin
                prime_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            prime_cnt_q <= '0;
            stable_q    <= BTN_RELEASED;
            press_q     <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prime_cnt_q <= prime_cnt_d;
            stable_q    <= stable_d;
            press_q     <= press_d;
            primed_q    <= primed_d;
        end
    end

    assign stable_n = stable_q;
    assign press    = press_q;

endmodule

// File: rtl/demo_start_ctrl.sv
// Turns a bouncy board button and mode switch into a clean start pulse
// and held mode level for one side of the dual bus demo.
module demo_start_ctrl
    import demo_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 5,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       mode_sw,
    input  logic       ready,
    output logic       start_n,
    output logic       mode,
    output logic       busy,
    output logic [7:0] press_count
);

    localparam int            PW         = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

    logic btn_stable_n;
    logic btn_press;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .din_n    (btn_n),
        .stable_n (btn_stable_n),
        .press    (btn_press)
    );

    // The mode switch is only sampled at press time, so no debounce is needed.
    logic [SYNC_STAGES-1:0] mode_sync_q;
    logic                   mode_synced;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_sync_q <= '1;
        end else begin
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], mode_sw};
        end
    end

    assign mode_synced = mode_sync_q[SYNC_STAGES-1];

    ctrl_state_e   state_q, state_d;
    logic          start_n_q, start_n_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] pulse_q, pulse_d;

    always_comb begin
        state_d   = state_q;
        start_n_d = start_n_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        count_d   = count_q;
        pulse_d   = pulse_q;

        case (state_q)
            IDLE: begin
                if (btn_press) begin
                    state_d = ARM;
                    mode_d  = mode_synced;
                    busy_d  = 1'b1;
                end
            end
            ARM: begin
                if (ready) begin
                    state_d   = FIRE;
                    count_d   = count_q + 8'd1;
                    pulse_d   = '0;
                    start_n_d = 1'b0;
                end
            end
            FIRE: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d   = RELEASE;
                    start_n_d = 1'b1;
                end else begin
                    pulse_d = pulse_q + PULSE_ONE;
                end
            end
            RELEASE: begin
                if (btn_stable_n == BTN_RELEASED) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                start_n_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            start_n_q <= 1'b1;
            mode_q    <= MODE_WRITE;
            busy_q    <= 1'b0;
            count_q   <= 8'd0;
            pulse_q   <= '0;
        end else begin
            state_q   <= state_d;
            start_n_q <= start_n_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
        end
    end

    assign start_n     = start_n_q;
    assign mode        = mode_q;
    assign busy        = busy_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_demo_start_ctrl.sv
// Directed bench for demo_start_ctrl with a cycle-level reference model.
module tb_demo_start_ctrl;

    localparam int DEB   = 8;
    localparam int PULSE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       mode_sw = 1'b1;
    logic       ready = 1'b1;
    logic       start_n;
    logic       mode;
    logic       busy;
    logic [7:0] press_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_falls = 0;

    demo_start_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_CYCLES    (PULSE),
        .SYNC_STAGES     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .mode_sw     (mode_sw),
        .ready       (ready),
        .start_n     (start_n),
        .mode        (mode),
        .busy        (busy),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    always @(negedge start_n) if (!rst) n_falls++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rules stated as run lengths, a pending request and a
    // remaining-pulse counter rather than a state machine.
    logic m_d1, m_d2, m_md1, m_md2, m_stable, m_primed, m_press;
    logic m_busy, m_pending, m_mode;
    int   m_diff_len, m_rel_len, m_pulse_left, m_count;

    task automatic model_step();
        logic p_new;
        if (rst) begin
            m_d1 = 1; m_d2 = 1; m_md1 = 1; m_md2 = 1;
            m_stable = 1; m_primed = 0; m_press = 0;
            m_busy = 0; m_pending = 0; m_mode = 1;
            m_diff_len = 0; m_rel_len = 0; m_pulse_left = 0; m_count = 0;
        end else begin
            if (!m_busy) begin
                if (m_press) begin
                    m_busy = 1; m_pending = 1; m_mode = m_md2;
                end
            end else if (m_pending) begin
                if (ready) begin
                    m_pending = 0; m_count = (m_count + 1) % 256; m_pulse_left = PULSE;
                end
            end else if (m_pulse_left > 0) begin
                m_pulse_left--;
            end else if (m_stable) begin
                m_busy = 0;
            end

            p_new = 0;
            if (m_d2 != m_stable) begin
                m_diff_len++;
                if (m_diff_len == DEB) begin
                    m_stable   = m_d2;
                    m_diff_len = 0;
                    p_new      = (m_stable == 0) && m_primed;
                end
            end else begin
                m_diff_len = 0;
            end
            if (!m_primed) begin
                if (m_d2) begin
                    m_rel_len++;
                    if (m_rel_len == DEB) m_primed = 1;
                end else begin
                    m_rel_len = 0;
                end
            end
            m_press = p_new;

            m_d2 = m_d1; m_d1 = btn_n;
            m_md2 = m_md1; m_md1 = mode_sw;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_start_n", 32'(start_n), 32'(m_pulse_left == 0));
            check("model_mode", 32'(mode), 32'(m_mode));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_count", 32'(press_count), 32'(m_count));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fall(output int cyc);
        cyc = 0;
        while (start_n !== 1'b0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (start_n === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic press_once(output int lat);
        int len;
        btn_n = 1'b0;
        wait_fall(lat);
        count_low(len);
        btn_n = 1'b1;
        wait_idle();
        tick(3);
    endtask

    initial begin
        int lat, len, falls0, cyc;

        tick(2);
        check("rst_start_n", 32'(start_n), 32'd1);
        check("rst_mode", 32'(mode), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(press_count), 32'd0);
        rst = 1'b0;
        tick(20);

        // 1: clean press, write mode, ready high
        falls0 = n_falls;
        mode_sw = 1'b1;
        btn_n = 1'b0;
        wait_fall(lat);
        check("t1_latency", 32'(lat), 32'd12);
        count_low(len);
        check("t1_pulse_len", 32'(len), 32'd5);
        check("t1_mode", 32'(mode), 32'd1);
        check("t1_count", 32'(press_count), 32'd1);
        tick(30 - lat - len);
        btn_n = 1'b1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t1_busy_fall", 32'(cyc), 32'd11);
        check("t1_falls", 32'(n_falls - falls0), 32'd1);
        tick(5);

        // 2: bouncing button never accepted
        falls0 = n_falls;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn_n = ~btn_n;
            tick(1);
        end
        btn_n = 1'b1;
        tick(30);
        check("t2_falls", 32'(n_falls - falls0), 32'd0);
        check("t2_count", 32'(press_count), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: ready low at press, released while waiting
        falls0 = n_falls;
        ready = 1'b0;
        btn_n = 1'b0;
        tick(20);
        btn_n = 1'b1;
        tick(30);
        check("t3_wait_start_n", 32'(start_n), 32'd1);
        check("t3_wait_busy", 32'(busy), 32'd1);
        ready = 1'b1;
        wait_fall(lat);
        check("t3_latency", 32'(lat), 32'd1);
        count_low(len);
        check("t3_pulse_len", 32'(len), 32'd5);
        tick(3);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_falls", 32'(n_falls - falls0), 32'd1);
        check("t3_count", 32'(press_count), 32'd2);

        // 4: mode latched at press only
        mode_sw = 1'b0;
        btn_n = 1'b0;
        wait_fall(lat);
        mode_sw = 1'b1;
        tick(2);
        check("t4_mode_fire", 32'(mode), 32'd0);
        tick(10);
        check("t4_mode_after", 32'(mode), 32'd0);
        btn_n = 1'b1;
        wait_idle();
        tick(3);
        check("t4_mode_idle", 32'(mode), 32'd0);
        press_once(lat);
        check("t4_mode2", 32'(mode), 32'd1);
        check("t4_count", 32'(press_count), 32'd4);

        // 5: async reset mid-pulse, held button must not fire afterwards
        btn_n = 1'b0;
        wait_fall(lat);
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_start_n", 32'(start_n), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_count", 32'(press_count), 32'd0);
        tick(3);
        rst = 1'b0;
        falls0 = n_falls;
        tick(40);
        check("t5_held_falls", 32'(n_falls - falls0), 32'd0);
        check("t5_held_busy", 32'(busy), 32'd0);
        btn_n = 1'b1;
        tick(25);
        press_once(lat);
        check("t5_latency", 32'(lat), 32'd12);
        check("t5_count", 32'(press_count), 32'd1);

        // 6: wrap the counter; glitch during FIRE adds nothing
        falls0 = n_falls;
        for (int i = 0; i < 254; i++) press_once(lat);
        check("t6_count_255", 32'(press_count), 32'd255);
        press_once(lat);
        check("t6_count_wrap", 32'(press_count), 32'd0);
        check("t6_falls", 32'(n_falls - falls0), 32'd255);
        falls0 = n_falls;
        btn_n = 1'b0;
        wait_fall(lat);
        tick(1);
        btn_n = 1'b1;
        tick(2);
        btn_n = 1'b0;
        tick(30);
        btn_n = 1'b1;
        wait_idle();
        tick(3);
        check("t6_glitch_falls", 32'(n_falls - falls0), 32'd1);
        check("t6_glitch_count", 32'(press_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
